mastermind_turn_ctrl: RTL and testbench
=======================================

Name: mastermind_turn_ctrl

Overview:
Game sequencer for the electronic Mastermind machine.
- Decides which player is codemaker and which is codebreaker.
- Collects 4-letter codes and guesses from SW on enterA/enterB presses and steers them into the secret-code and guess registers.
- Starts the feedback comparator and counts guess attempts.
- Awards points, advances rounds, swaps roles and declares the winner.
- Sits between the player inputs and the compare/LED datapath, replacing ad-hoc control in the top level.

Parameters:
MAX_GUESSES, 3, guesses the breaker gets per round (1..3)
WIN_SCORE, 2, score that ends the game (1..3)
FB_HOLD, 8, cycles the feedback result is held valid after a compare (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
enterA  in  1  player A enter button (level, synchronised upstream)
enterB  in  1  player B enter button
SW  in  3  letter code; 3'b000 = no letter
cmp_done  in  1  comparator finished (1-cycle pulse)
cmp_exact  in  3  exact-position matches reported with cmp_done (0..4)
code_we  out  1  write strobe into secret-code register
guess_we  out  1  write strobe into guess register
wr_idx  out  2  letter slot 0..3 for code_we/guess_we
wr_data  out  3  letter written (registered copy of SW)
cmp_start  out  1  1-cycle pulse to start the comparator
fb_valid  out  1  high while the feedback LEDs show a valid result
maker_is_b  out  1  0: A is maker, 1: B is maker
guess_num  out  2  current guess attempt, 1-based; 0 outside BREAKER
state_disp  out  3  encoded FSM state
round_count  out  2  completed rounds, wraps 3->0
scoreA  out  2  player A score
scoreB  out  2  player B score
game_over  out  1  game finished
winner_b  out  1  valid with game_over; 1 = B won

Behaviour:
- Edge detection: pressA = enterA & ~enterA_q; pressB likewise. A held button counts once.
- Reset (reset==0 at a clk edge) forces:
  - state START;
  - all strobes, fb_valid, game_over, winner_b, maker_is_b = 0;
  - scores, round_count, guess_num, wr_idx, wr_data = 0;
  - edge registers cleared.
  - Reset mid-round discards all progress.
- START (0): first press picks the maker: pressA -> maker_is_b=0; pressB -> maker_is_b=1. Simultaneous presses -> A wins. Next state MAKER, slot=0.
- MAKER (1):
  - Only a maker press with SW!=0 is accepted; SW==0 presses are ignored.
  - On an accepted press: code_we=1, wr_idx=slot, wr_data=SW on the next cycle (1-cycle latency, 1-cycle pulse); then slot++.
  - After slot 3 is written -> BREAKER, slot=0, guess_num=1.
- BREAKER (2): same rule for breaker presses using guess_we. After slot 3 is written -> CHECK.
- Presses from the inactive player are ignored in every state.
- CHECK (3): cmp_start pulses in the first CHECK cycle only. Wait for cmp_done; no timeout. On cmp_done, latch hit = (cmp_exact==4) -> SHOW.
- SHOW (4):
  - fb_valid=1 for exactly FB_HOLD cycles; all presses ignored.
  - Then: if hit or guess_num==MAX_GUESSES -> ROUND_END; else guess_num++, slot=0 -> BREAKER.
- ROUND_END (5), one cycle:
  - If hit, the breaker's score +1; else the maker's score +1.
  - round_count +1, mod 4.
  - maker_is_b toggles; guess_num=0.
  - If the updated score reaches WIN_SCORE -> GAME_OVER with winner_b set; else -> MAKER with slot=0.
- GAME_OVER (6): game_over=1; scores frozen. Any press clears scores, round_count, game_over and winner_b -> START.
- Scores are 2-bit and saturate at 3; they cannot exceed WIN_SCORE.
- Unused encoding 7 -> START.

Decomposition:
- Shared package mastermind_pkg holds:
  - state encodings ST_START..ST_GAME_OVER;
  - LETTER_NONE = 3'b000;
  - CODE_LEN = 4;
  - the letter codes A=001, C=010, E=011, F=100, U=111.
- One sub-module, press_edge_detect: 1-bit rising-edge detector with synchronous active-low clear, instantiated for A and B.
- Everything else lives in the single FSM module.

Test Plan:
- Reset released, pressA, A enters F,A,C,E (100,001,010,011) -> four code_we pulses, wr_idx 0..3, wr_data matching; state BREAKER; maker_is_b=0.
- B guesses F,A,C,E, model returns cmp_exact=4 -> one cmp_start; fb_valid high exactly 8 cycles; scoreB=1, round_count=1, maker_is_b=1.
- Round 2: B enters U,U,U,U; A guesses A,A,A,A three times with cmp_exact=0 -> guess_num 1,2,3; scoreB=2; game_over=1, winner_b=1.
- pressA and pressB in the same cycle in START -> maker_is_b=0. pressB while A makes the code, SW=000 presses and presses during SHOW -> no strobes, slot unchanged.
- reset low during BREAKER slot 2 -> next cycle all outputs at reset values, state START. Button held high 20 cycles -> exactly one letter accepted.
- In GAME_OVER any press -> scores 0, round_count 0, state START. cmp_done delayed 50 cycles -> controller waits in CHECK with no second cmp_start.

Source files
------------

// File: rtl/mastermind_turn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mastermind_pkg
// Shared definitions for the Mastermind turn controller: FSM state encodings,
// letter codes, code length and a saturating score increment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package mastermind_pkg;

    localparam logic [2:0] ST_START     = 3'd0;
    localparam logic [2:0] ST_MAKER     = 3'd1;
    localparam logic [2:0] ST_BREAKER   = 3'd2;
    localparam logic [2:0] ST_CHECK     = 3'd3;
    localparam logic [2:0] ST_SHOW      = 3'd4;
    localparam logic [2:0] ST_ROUND_END = 3'd5;
    localparam logic [2:0] ST_GAME_OVER = 3'd6;

    typedef logic [2:0] letter_t;
    typedef logic [1:0] score_t;

    localparam letter_t LETTER_NONE = 3'b000;
    localparam letter_t LETTER_A    = 3'b001;
    localparam letter_t LETTER_C    = 3'b010;
    localparam letter_t LETTER_E    = 3'b011;
    localparam letter_t LETTER_F    = 3'b100;
    localparam letter_t LETTER_U    = 3'b111;

    localparam int CODE_LEN = 4;

    // Scores are 2 bits wide and stick at 3 rather than wrapping.
    function automatic score_t sat_inc(input score_t s);
        return (s == 2'd3) ? s : s + 2'd1;
    endfunction

endpackage

// File: rtl/mastermind_turn_ctrl_if.sv
// -----------------------------------------------------------------------------
// mastermind_turn_ctrl_if
// Connection between the turn controller and the compare/LED datapath.
//   code_we / guess_we : write strobes into secret-code / guess register
//   wr_idx, wr_data    : letter slot and letter for the strobes
//   cmp_start          : 1-cycle comparator start pulse
//   cmp_done           : comparator finished (1-cycle pulse)
//   cmp_exact          : exact-position matches, valid with cmp_done
//   fb_valid           : feedback LEDs show a valid result
// master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface mastermind_turn_ctrl_if;
    logic       code_we;
    logic       guess_we;
    logic [1:0] wr_idx;
    logic [2:0] wr_data;
    logic       cmp_start;
    logic       cmp_done;
    logic [2:0] cmp_exact;
    logic       fb_valid;

    modport master (
        output code_we, guess_we, wr_idx, wr_data, cmp_start, fb_valid,
        input  cmp_done, cmp_exact
    );

    modport slave (
        input  code_we, guess_we, wr_idx, wr_data, cmp_start, fb_valid,
        output cmp_done, cmp_exact
    );
endinterface

// File: rtl/mastermind_turn_ctrl_press_edge_detect.sv
// -----------------------------------------------------------------------------
// press_edge_detect
// Rising-edge detector for a (pre-synchronised) button level.
//   clk   : system clock
//   reset : synchronous active-low clear of the history flop
//   btn   : button level
//   press : high for the single cycle in which btn rises
// -----------------------------------------------------------------------------
module press_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic btn_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn;
        end
    end

    assign press = btn & ~btn_q;

endmodule

// File: rtl/mastermind_turn_ctrl.sv
// -----------------------------------------------------------------------------
// mastermind_turn_ctrl
// Game sequencer for the electronic Mastermind machine: picks roles, steers
// code/guess letters into the datapath, runs the comparator, holds feedback,
// keeps score and declares the winner.
//   clk, reset   : system clock, synchronous active-low reset
//   enterA/B     : player enter buttons (levels)
//   SW           : letter code, 3'b000 = no letter
//   bus          : datapath connection (strobes, comparator, fb_valid)
//   maker_is_b   : 0 = A is codemaker, 1 = B is codemaker
//   guess_num    : current guess attempt (1-based) in BREAKER, else 0
//   state_disp   : encoded FSM state
//   round_count  : completed rounds, modulo 4
//   scoreA/B     : player scores
//   game_over    : game finished, winner_b valid
//   winner_b     : 1 = B won
//
// state      | meaning
// -----------+----------------------------------------------------
// START      | wait for first press, presser becomes codemaker
// MAKER      | maker enters 4 code letters
// BREAKER    | breaker enters 4 guess letters
// CHECK      | comparator started, waiting for cmp_done
// SHOW       | feedback held valid for FB_HOLD cycles
// ROUND_END  | award point, swap roles, check for a winner
// GAME_OVER  | scores frozen until any press
// -----------------------------------------------------------------------------
module mastermind_turn_ctrl
    import mastermind_pkg::*;
#(
    parameter int MAX_GUESSES = 3,
    parameter int WIN_SCORE   = 2,
    parameter int FB_HOLD     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enterA,
    input  logic                  enterB,
    input  logic [2:0]            SW,
    mastermind_turn_ctrl_if.master bus,
    output logic                  maker_is_b,
    output logic [1:0]            guess_num,
    output logic [2:0]            state_disp,
    output logic [1:0]            round_count,
    output logic [1:0]            scoreA,
    output logic [1:0]            scoreB,
    output logic                  game_over,
    output logic                  winner_b
);

    localparam int         FB_W      = (FB_HOLD > 1) ? $clog2(FB_HOLD) : 1;
    localparam logic [FB_W-1:0] FB_LOAD = FB_W'(FB_HOLD - 1);
    localparam logic [1:0] LAST_SLOT = 2'(CODE_LEN - 1);
    localparam logic [1:0] MAX_G     = 2'(MAX_GUESSES);
    localparam logic [1:0] WIN_S     = 2'(WIN_SCORE);

    logic [2:0]      state;
    logic [1:0]      slot;
    logic [1:0]      guess_cnt;
    logic            hit;
    logic [FB_W-1:0] fb_cnt;

    logic   press_a;
    logic   press_b;
    logic   maker_press;
    logic   breaker_press;
    logic   letter_ok;
    logic   b_scores;
    score_t score_a_nxt;
    score_t score_b_nxt;
    logic   win_reached;

    press_edge_detect u_edge_a (
        .clk   (clk),
        .reset (reset),
        .btn   (enterA),
        .press (press_a)
    );

    press_edge_detect u_edge_b (
        .clk   (clk),
        .reset (reset),
        .btn   (enterB),
        .press (press_b)
    );

    assign maker_press   = maker_is_b ? press_b : press_a;
    assign breaker_press = maker_is_b ? press_a : press_b;
    assign letter_ok     = (SW != LETTER_NONE);

    // Point goes to the breaker on a hit, otherwise to the maker.
    always_comb begin
        b_scores    = hit ? ~maker_is_b : maker_is_b;
        score_a_nxt = b_scores ? scoreA : sat_inc(scoreA);
        score_b_nxt = b_scores ? sat_inc(scoreB) : scoreB;
        win_reached = b_scores ? (score_b_nxt >= WIN_S) : (score_a_nxt >= WIN_S);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= ST_START;
            slot          <= 2'd0;
            guess_cnt     <= 2'd0;
            hit           <= 1'b0;
            fb_cnt        <= '0;
            maker_is_b    <= 1'b0;
            round_count   <= 2'd0;
            scoreA        <= 2'd0;
            scoreB        <= 2'd0;
            game_over     <= 1'b0;
            winner_b      <= 1'b0;
            bus.code_we   <= 1'b0;
            bus.guess_we  <= 1'b0;
            bus.wr_idx    <= 2'd0;
            bus.wr_data   <= 3'd0;
            bus.cmp_start <= 1'b0;
            bus.fb_valid  <= 1'b0;
        end else begin
            bus.code_we   <= 1'b0;
            bus.guess_we  <= 1'b0;
            bus.cmp_start <= 1'b0;

            case (state)
                ST_START: begin
                    if (press_a || press_b) begin
                        // Simultaneous presses: A takes the maker role.
                        maker_is_b <= ~press_a;
                        slot       <= 2'd0;
                        state      <= ST_MAKER;
                    end
                end

                ST_MAKER: begin
                    if (maker_press && letter_ok) begin
                        bus.code_we <= 1'b1;
                        bus.wr_idx  <= slot;
                        bus.wr_data <= SW;
                        if (slot == LAST_SLOT) begin
                            slot      <= 2'd0;
                            guess_cnt <= 2'd1;
                            state     <= ST_BREAKER;
                        end else begin
                            slot <= slot + 2'd1;
                        end
                    end
                end

                ST_BREAKER: begin
                    if (breaker_press && letter_ok) begin
                        bus.guess_we <= 1'b1;
                        bus.wr_idx   <= slot;
                        bus.wr_data  <= SW;
                        if (slot == LAST_SLOT) begin
                            slot          <= 2'd0;
                            bus.cmp_start <= 1'b1;
                            state         <= ST_CHECK;
                        end else begin
                            slot <= slot + 2'd1;
                        end
                    end
                end

                ST_CHECK: begin
                    if (bus.cmp_done) begin
                        hit          <= (bus.cmp_exact == 3'd4);
                        fb_cnt       <= FB_LOAD;
                        bus.fb_valid <= 1'b1;
                        state        <= ST_SHOW;
                    end
                end

                ST_SHOW: begin
                    if (fb_cnt == '0) begin
                        bus.fb_valid <= 1'b0;
                        if (hit || guess_cnt == MAX_G) begin
                            state <= ST_ROUND_END;
                        end else begin
                            guess_cnt <= guess_cnt + 2'd1;
                            slot      <= 2'd0;
                            state     <= ST_BREAKER;
                        end
                    end else begin
                        fb_cnt <= fb_cnt - 1'b1;
                    end
                end

                ST_ROUND_END: begin
                    scoreA      <= score_a_nxt;
                    scoreB      <= score_b_nxt;
                    round_count <= round_count + 2'd1;
                    maker_is_b  <= ~maker_is_b;
                    guess_cnt   <= 2'd0;
                    slot        <= 2'd0;
                    if (win_reached) begin
                        game_over <= 1'b1;
                        winner_b  <= b_scores;
                        state     <= ST_GAME_OVER;
                    end else begin
                        state <= ST_MAKER;
                    end
                end

                ST_GAME_OVER: begin
                    if (press_a || press_b) begin
                        scoreA      <= 2'd0;
                        scoreB      <= 2'd0;
                        round_count <= 2'd0;
                        game_over   <= 1'b0;
                        winner_b    <= 1'b0;
                        state       <= ST_START;
                    end
                end

                default: state <= ST_START;
            endcase
        end
    end

    assign state_disp = state;
    assign guess_num  = (state == ST_BREAKER) ? guess_cnt : 2'd0;

endmodule

// File: tb/tb_mastermind_turn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mastermind_turn_ctrl
// Bench for mastermind_turn_ctrl: a vector table for the code/guess entry
// of round 1, then hand-written sequences for feedback hold, scoring, role
// swap, multi-guess rounds, game over, held buttons, slow comparator and
// mid-round reset. A small datapath model captures written letters and
// answers cmp_start with the exact-match count after cmp_delay cycles.
// -----------------------------------------------------------------------------
module tb_mastermind_turn_ctrl;
    import mastermind_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enterA, enterB;
    logic [2:0] SW;
    logic       maker_is_b;
    logic [1:0] guess_num;
    logic [2:0] state_disp;
    logic [1:0] round_count;
    logic [1:0] scoreA, scoreB;
    logic       game_over, winner_b;

    mastermind_turn_ctrl_if mif ();

    mastermind_turn_ctrl #(
        .MAX_GUESSES (3),
        .WIN_SCORE   (2),
        .FB_HOLD     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enterA      (enterA),
        .enterB      (enterB),
        .SW          (SW),
        .bus         (mif),
        .maker_is_b  (maker_is_b),
        .guess_num   (guess_num),
        .state_disp  (state_disp),
        .round_count (round_count),
        .scoreA      (scoreA),
        .scoreB      (scoreB),
        .game_over   (game_over),
        .winner_b    (winner_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // datapath model state
    logic [2:0] secret [4];
    logic [2:0] guess  [4];
    int n_code_we = 0, n_guess_we = 0, n_cmp_start = 0, n_fb = 0;
    int cmp_delay = 2;
    int cd = 0;

    function automatic logic [2:0] exact_count();
        logic [2:0] n = 3'd0;
        for (int i = 0; i < 4; i++) if (secret[i] == guess[i]) n = n + 3'd1;
        return n;
    endfunction

    initial begin
        mif.cmp_done  = 1'b0;
        mif.cmp_exact = 3'd0;
        for (int i = 0; i < 4; i++) begin
            secret[i] = 3'd0;
            guess[i]  = 3'd0;
        end
        forever begin
            @(negedge clk);
            mif.cmp_done = 1'b0;
            if (mif.code_we)  begin secret[mif.wr_idx] = mif.wr_data; n_code_we++;  end
            if (mif.guess_we) begin guess[mif.wr_idx]  = mif.wr_data; n_guess_we++; end
            if (mif.fb_valid) n_fb++;
            if (mif.cmp_start) begin
                n_cmp_start++;
                cd = cmp_delay;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mif.cmp_exact = exact_count();
                    mif.cmp_done  = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // observed values one cycle after a press edge
    logic       obs_cwe, obs_gwe;
    logic [1:0] obs_idx;
    logic [2:0] obs_data, obs_state;

    task automatic press(input logic a, input logic b, input logic [2:0] sw);
        enterA = a;
        enterB = b;
        SW     = sw;
        tick();
        obs_cwe   = mif.code_we;
        obs_gwe   = mif.guess_we;
        obs_idx   = mif.wr_idx;
        obs_data  = mif.wr_data;
        obs_state = state_disp;
        enterA = 1'b0;
        enterB = 1'b0;
        tick();
    endtask

    task automatic wait_state(input logic [2:0] s, input int max, input string nm);
        int k = 0;
        while (state_disp !== s && k < max) begin
            tick();
            k++;
        end
        chk(nm, int'(state_disp), int'(s));
    endtask

    task automatic enter4(input logic a, input logic b, input logic [2:0] sw);
        for (int i = 0; i < 4; i++) press(a, b, sw);
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_state"},     int'(state_disp),    int'(ST_START));
        chk({pfx, "_code_we"},   int'(mif.code_we),   0);
        chk({pfx, "_guess_we"},  int'(mif.guess_we),  0);
        chk({pfx, "_cmp_start"}, int'(mif.cmp_start), 0);
        chk({pfx, "_fb_valid"},  int'(mif.fb_valid),  0);
        chk({pfx, "_wr_idx"},    int'(mif.wr_idx),    0);
        chk({pfx, "_wr_data"},   int'(mif.wr_data),   0);
        chk({pfx, "_maker_b"},   int'(maker_is_b),    0);
        chk({pfx, "_guess_num"}, int'(guess_num),     0);
        chk({pfx, "_round"},     int'(round_count),   0);
        chk({pfx, "_scoreA"},    int'(scoreA),        0);
        chk({pfx, "_scoreB"},    int'(scoreB),        0);
        chk({pfx, "_game_over"}, int'(game_over),     0);
        chk({pfx, "_winner_b"},  int'(winner_b),      0);
    endtask

    typedef struct packed {
        logic       a;
        logic       b;
        logic [2:0] sw;
        logic       exp_cwe;
        logic       exp_gwe;
        logic [1:0] exp_idx;
        logic [2:0] exp_data;
        logic [2:0] exp_state;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int c0, g0, s0;

        //            a  b  sw        cwe gwe idx  data      state
        vecs[0]  = '{1'b1, 1'b1, LETTER_NONE, 1'b0, 1'b0, 2'd0, 3'd0,     ST_MAKER};
        vecs[1]  = '{1'b0, 1'b1, LETTER_F,    1'b0, 1'b0, 2'd0, 3'd0,     ST_MAKER};
        vecs[2]  = '{1'b1, 1'b0, LETTER_NONE, 1'b0, 1'b0, 2'd0, 3'd0,     ST_MAKER};
        vecs[3]  = '{1'b1, 1'b0, LETTER_F,    1'b1, 1'b0, 2'd0, LETTER_F, ST_MAKER};
        vecs[4]  = '{1'b1, 1'b0, LETTER_A,    1'b1, 1'b0, 2'd1, LETTER_A, ST_MAKER};
        vecs[5]  = '{1'b1, 1'b0, LETTER_C,    1'b1, 1'b0, 2'd2, LETTER_C, ST_MAKER};
        vecs[6]  = '{1'b1, 1'b0, LETTER_E,    1'b1, 1'b0, 2'd3, LETTER_E, ST_BREAKER};
        vecs[7]  = '{1'b1, 1'b0, LETTER_F,    1'b0, 1'b0, 2'd0, 3'd0,     ST_BREAKER};
        vecs[8]  = '{1'b0, 1'b1, LETTER_F,    1'b0, 1'b1, 2'd0, LETTER_F, ST_BREAKER};
        vecs[9]  = '{1'b0, 1'b1, LETTER_A,    1'b0, 1'b1, 2'd1, LETTER_A, ST_BREAKER};
        vecs[10] = '{1'b0, 1'b1, LETTER_C,    1'b0, 1'b1, 2'd2, LETTER_C, ST_BREAKER};
        vecs[11] = '{1'b0, 1'b1, LETTER_E,    1'b0, 1'b1, 2'd3, LETTER_E, ST_CHECK};

        reset  = 1'b0;
        enterA = 1'b0;
        enterB = 1'b0;
        SW     = 3'd0;
        repeat (3) tick();
        check_reset_outputs("rst0");
        reset = 1'b1;
        tick();

        // ---- round 1: table-driven entry, A maker (both pressed in START)
        for (int i = 0; i < 12; i++) begin
            press(vecs[i].a, vecs[i].b, vecs[i].sw);
            chk($sformatf("vec%0d_state", i),    int'(obs_state), int'(vecs[i].exp_state));
            chk($sformatf("vec%0d_code_we", i),  int'(obs_cwe),   int'(vecs[i].exp_cwe));
            chk($sformatf("vec%0d_guess_we", i), int'(obs_gwe),   int'(vecs[i].exp_gwe));
            if (vecs[i].exp_cwe || vecs[i].exp_gwe) begin
                chk($sformatf("vec%0d_wr_idx", i),  int'(obs_idx),  int'(vecs[i].exp_idx));
                chk($sformatf("vec%0d_wr_data", i), int'(obs_data), int'(vecs[i].exp_data));
            end
            if (i == 6) begin
                chk("r1_maker_is_b", int'(maker_is_b), 0);
                chk("r1_guess_num",  int'(guess_num),  1);
            end
        end
        chk("r1_code_we_count", n_code_we, 4);

        // ---- round 1 feedback: hit, presses during SHOW ignored
        wait_state(ST_SHOW, 20, "r1_reach_show");
        c0 = n_code_we;
        g0 = n_guess_we;
        press(1'b0, 1'b1, LETTER_F);
        press(1'b1, 1'b0, LETTER_C);
        chk("show_press_state",    int'(state_disp), int'(ST_SHOW));
        chk("show_press_code_we",  n_code_we,  c0);
        chk("show_press_guess_we", n_guess_we, g0);
        wait_state(ST_MAKER, 40, "r1_back_to_maker");
        chk("r1_fb_cycles",   n_fb,              8);
        chk("r1_cmp_starts",  n_cmp_start,       1);
        chk("r1_scoreA",      int'(scoreA),      0);
        chk("r1_scoreB",      int'(scoreB),      1);
        chk("r1_round_count", int'(round_count), 1);
        chk("r1_maker_is_b",  int'(maker_is_b),  1);
        chk("r1_guess_num",   int'(guess_num),   0);

        // ---- round 2: B maker, held button counts once
        c0 = n_code_we;
        enterB = 1'b1;
        SW     = LETTER_U;
        repeat (20) tick();
        enterB = 1'b0;
        tick();
        chk("held_btn_code_we", n_code_we, c0 + 1);
        press(1'b1, 1'b0, LETTER_U);
        chk("r2_inactive_a", n_code_we, c0 + 1);
        for (int i = 0; i < 3; i++) press(1'b0, 1'b1, LETTER_U);
        chk("r2_code_we_count", n_code_we, c0 + 4);
        chk("r2_state_breaker", int'(state_disp), int'(ST_BREAKER));
        chk("r2_guess_num1",    int'(guess_num),  1);

        // guess 1 with a slow comparator
        cmp_delay = 50;
        s0 = n_cmp_start;
        enter4(1'b1, 1'b0, LETTER_A);
        repeat (40) tick();
        chk("slow_cmp_state",  int'(state_disp), int'(ST_CHECK));
        chk("slow_cmp_starts", n_cmp_start,      s0 + 1);
        cmp_delay = 2;
        wait_state(ST_SHOW, 40, "r2_g1_show");
        wait_state(ST_BREAKER, 40, "r2_g1_breaker");
        chk("r2_guess_num2", int'(guess_num), 2);

        enter4(1'b1, 1'b0, LETTER_A);
        wait_state(ST_SHOW, 40, "r2_g2_show");
        wait_state(ST_BREAKER, 40, "r2_g2_breaker");
        chk("r2_guess_num3", int'(guess_num), 3);

        enter4(1'b1, 1'b0, LETTER_A);
        wait_state(ST_GAME_OVER, 100, "r2_game_over_state");
        chk("go_game_over",   int'(game_over),   1);
        chk("go_winner_b",    int'(winner_b),    1);
        chk("go_scoreA",      int'(scoreA),      0);
        chk("go_scoreB",      int'(scoreB),      2);
        chk("go_round_count", int'(round_count), 2);
        chk("go_starts",      n_cmp_start,       s0 + 3);
        repeat (5) tick();
        chk("go_frozen_scoreB", int'(scoreB), 2);
        chk("go_frozen_state",  int'(state_disp), int'(ST_GAME_OVER));

        press(1'b0, 1'b1, LETTER_NONE);
        chk("clr_state",     int'(state_disp),  int'(ST_START));
        chk("clr_scoreA",    int'(scoreA),      0);
        chk("clr_scoreB",    int'(scoreB),      0);
        chk("clr_round",     int'(round_count), 0);
        chk("clr_game_over", int'(game_over),   0);
        chk("clr_winner_b",  int'(winner_b),    0);

        // ---- reset in BREAKER slot 2
        press(1'b1, 1'b0, LETTER_NONE);
        chk("rs_maker_a", int'(maker_is_b), 0);
        press(1'b1, 1'b0, LETTER_F);
        press(1'b1, 1'b0, LETTER_A);
        press(1'b1, 1'b0, LETTER_C);
        press(1'b1, 1'b0, LETTER_E);
        press(1'b0, 1'b1, LETTER_C);
        press(1'b0, 1'b1, LETTER_U);
        chk("rs_pre_state", int'(state_disp), int'(ST_BREAKER));
        enterB = 1'b1;
        SW     = LETTER_E;
        reset  = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        enterB = 1'b0;
        reset  = 1'b1;
        tick();
        chk("rst_after_state", int'(state_disp), int'(ST_START));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
